// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between I-side and D-side MMU refill paths
// Optional MEMARB_ROUND_ROBIN_EN replaces D-priority plus starvation guard with round-robin arbitration.
module mem_port_arbiter #(
  parameter int LATENCY     = 2,
  parameter int MAX_D_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_bsel,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [3:0]  mem_bsel,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        grant_d;   // side of the current/most recent grant; doubles as last_grant
  logic        win_d;
  logic [31:0] lat_addr, lat_wdata;
  logic [3:0]  lat_bsel;
  logic        lat_wen;

`ifdef MEMARB_ROUND_ROBIN_EN
  always_comb begin
    win_d = d_req;
    if (d_req && i_req) win_d = !grant_d;
  end
`else
  localparam logic [3:0] MAX_B = 4'(MAX_D_BURST);
  logic [3:0] starve_cnt;

  always_comb begin
    win_d = d_req;
    if (d_req && i_req) win_d = (starve_cnt != MAX_B);
  end

  // Counts D grants made while I waits; any I grant or an idle I side clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!i_req)     starve_cnt <= 4'd0;
      else if (win_d) starve_cnt <= starve_cnt + 4'd1;
      else            starve_cnt <= 4'd0;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_bsel  = 4'd0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (i_req || d_req) state_nxt = ACCESS;
      ACCESS: begin
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        mem_bsel  = lat_bsel;
        mem_ren   = !lat_wen;
        mem_wen   = lat_wen;
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        i_ack     = !grant_d;
        d_ack     = grant_d;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      grant_d   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_bsel  <= 4'd0;
      lat_wen   <= 1'b0;
      i_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: if (i_req || d_req) begin
          grant_d <= win_d;
          cnt     <= LAT_M1;
          if (win_d) begin
            lat_addr  <= d_addr;
            lat_wdata <= d_wdata;
            lat_bsel  <= d_bsel;
            lat_wen   <= d_wen;
          end else begin
            lat_addr  <= i_addr;
            lat_wdata <= 32'd0;
            lat_bsel  <= 4'b1111;
            lat_wen   <= 1'b0;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_wen) begin
              if (grant_d) d_rdata <= mem_rdata;
              else         i_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (LATENCY=2 and LATENCY=1 instances)
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int LAT  = 2;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_wen, i_ack, d_ack, mem_ren, mem_wen, busy;
  logic [31:0] i_addr, d_addr, d_wdata, i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  d_bsel, mem_bsel;

  logic        l1_i_req, l1_d_req, l1_d_wen, l1_i_ack, l1_d_ack, l1_mem_ren, l1_mem_wen, l1_busy;
  logic [31:0] l1_i_addr, l1_d_addr, l1_d_wdata, l1_i_rdata, l1_d_rdata;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [3:0]  l1_d_bsel, l1_mem_bsel;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata    = mem_model(mem_addr);
  assign l1_mem_rdata = mem_model(l1_mem_addr);

  mem_port_arbiter #(.LATENCY(LAT), .MAX_D_BURST(MAXB)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_bsel(d_bsel),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_bsel(mem_bsel), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.LATENCY(1), .MAX_D_BURST(MAXB)) dut1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(l1_i_addr), .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_wen(l1_d_wen), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata), .d_bsel(l1_d_bsel),
    .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
    .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_ren(l1_mem_ren), .mem_wen(l1_mem_wen),
    .mem_bsel(l1_mem_bsel), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  typedef struct {
    logic        is_d;
    logic        wen;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        m_last_d;
  int          m_scnt;
  logic [31:0] m_i_rdata, m_d_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_d  = 1'b0;
    m_scnt    = 0;
    m_i_rdata = 32'd0;
    m_d_rdata = 32'd0;
    sb.delete();
  endtask

  // Compares the ack pair and the winner's read data against a popped scoreboard entry.
  task automatic check_ack(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL %s: unexpected ack {d,i}=%b with empty scoreboard", name, {d_ack, i_ack});
      return;
    end
    e = sb.pop_front();
    vectors++;
    if ({d_ack, i_ack} !== (e.is_d ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL %s ack side: got {d,i}=%b expected %b", name, {d_ack, i_ack}, e.is_d ? 2'b10 : 2'b01);
    end
    if (e.is_d && !e.wen) m_d_rdata = e.rdata;
    if (!e.is_d)          m_i_rdata = e.rdata;
    vectors++;
    if (d_rdata !== m_d_rdata || i_rdata !== m_i_rdata) begin
      miscompares++;
      $display("FAIL %s rdata: got d=%h i=%h expected d=%h i=%h", name, d_rdata, i_rdata, m_d_rdata, m_i_rdata);
    end
    m_last_d = e.is_d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {i_req, d_req, d_wen} = '0; i_addr = '0; d_addr = '0; d_wdata = '0; d_bsel = '0;
    {l1_i_req, l1_d_req, l1_d_wen} = '0; l1_i_addr = '0; l1_d_addr = '0; l1_d_wdata = '0; l1_d_bsel = '0;
    step(); step();
    vectors++;
    if ({i_ack, d_ack, mem_ren, mem_wen, busy, mem_bsel} !== 9'd0 ||
        {i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got ack=%b%b ren=%b wen=%b busy=%b bsel=%h irdata=%h drdata=%h addr=%h expected all 0",
               i_ack, d_ack, mem_ren, mem_wen, busy, mem_bsel, i_rdata, d_rdata, mem_addr);
    end
    reset = 1'b0;
    model_reset();
    step();
  endtask

  task automatic do_txn(input logic is_d, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] bsel, input string name);
    exp_t        e;
    int          ren_n, wen_n, ack_at;
    logic [3:0]  exp_bsel;
    e.is_d  = is_d;
    e.wen   = wen;
    e.rdata = mem_model(addr);
    sb.push_back(e);
    exp_bsel = is_d ? bsel : 4'hF;
    if (is_d) begin
      d_req = 1'b1; d_wen = wen; d_addr = addr; d_wdata = wdata; d_bsel = bsel;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    ren_n = 0; wen_n = 0; ack_at = 0;
    for (int k = 1; k <= 20 && ack_at == 0; k++) begin
      step();
      if (mem_ren || mem_wen) begin
        ren_n += int'(mem_ren);
        wen_n += int'(mem_wen);
        vectors++;
        if (mem_addr !== addr || mem_bsel !== exp_bsel || (wen && mem_wdata !== wdata)) begin
          miscompares++;
          $display("FAIL %s mem bus: got addr=%h bsel=%h wdata=%h expected addr=%h bsel=%h wdata=%h",
                   name, mem_addr, mem_bsel, mem_wdata, addr, exp_bsel, wdata);
        end
      end
      if (i_ack || d_ack) begin
        ack_at = k;
        check_ack(name);
        i_req = 1'b0; d_req = 1'b0;
      end
    end
    vectors++;
    if (ack_at != LAT + 1) begin
      miscompares++;
      $display("FAIL %s latency: ack at step %0d expected %0d", name, ack_at, LAT + 1);
    end
    vectors++;
    if (ren_n != (wen ? 0 : LAT) || wen_n != (wen ? LAT : 0)) begin
      miscompares++;
      $display("FAIL %s strobes: got ren=%0d wen=%0d cycles expected ren=%0d wen=%0d",
               name, ren_n, wen_n, wen ? 0 : LAT, wen ? LAT : 0);
    end
    m_scnt = 0;
    step();
    vectors++;
    if (busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL %s return idle: got busy=%b acks=%b%b expected 0", name, busy, i_ack, d_ack);
    end
  endtask

  task automatic test_i_read();
    do_txn(1'b0, 1'b0, 32'h100, 32'd0, 4'd0, "i_read");
  endtask

  task automatic test_d_write();
    do_txn(1'b1, 1'b0, 32'h300, 32'd0, 4'hF, "d_read_pre");
    do_txn(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011, "d_write");
    do_txn(1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 4'b0000, "d_write_bsel0");
  endtask

  // Pushes the model's next winner when both sides request in IDLE.
  task automatic push_winner(input logic [31:0] i_a, input logic [31:0] d_a);
    exp_t e;
`ifdef MEMARB_ROUND_ROBIN_EN
    e.is_d   = !m_last_d;
    m_last_d = e.is_d;
`else
    if (m_scnt == MAXB) begin
      e.is_d = 1'b0; m_scnt = 0;
    end else begin
      e.is_d = 1'b1; m_scnt++;
    end
`endif
    e.wen   = 1'b0;
    e.rdata = mem_model(e.is_d ? d_a : i_a);
    sb.push_back(e);
  endtask

  task automatic test_same_edge();
    int acks, first_at, second_at;
    push_winner(32'h500, 32'h400);
    sb.push_back('{is_d: !sb[0].is_d, wen: 1'b0, rdata: mem_model(sb[0].is_d ? 32'h500 : 32'h400)});
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h400;
    acks = 0; first_at = 0; second_at = 0;
    for (int k = 1; k <= 30 && acks < 2; k++) begin
      step();
      if (i_ack || d_ack) begin
        if (d_ack) d_req = 1'b0;
        if (i_ack) i_req = 1'b0;
        check_ack("same_edge");
        acks++;
        if (acks == 1) first_at = k; else second_at = k;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    m_scnt = 0;
    vectors++;
    if (first_at != LAT + 1 || second_at != 2 * LAT + 3) begin
      miscompares++;
      $display("FAIL same_edge timing: acks at %0d,%0d expected %0d,%0d", first_at, second_at, LAT + 1, 2 * LAT + 3);
    end
    step(); step();
  endtask

  task automatic test_back_to_back();
    int acks, prev_at;
    for (int n = 0; n < 10; n++) push_winner(32'h700, 32'h600);
    i_req = 1'b1; i_addr = 32'h700;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h600;
    acks = 0; prev_at = 0;
    for (int k = 1; k <= 10 * (LAT + 2) + 20 && acks < 10; k++) begin
      step();
      if (i_ack || d_ack) begin
        check_ack("back_to_back");
        if (acks > 0) begin
          vectors++;
          if (k - prev_at != LAT + 2) begin
            miscompares++;
            $display("FAIL back_to_back spacing: got %0d cycles expected %0d", k - prev_at, LAT + 2);
          end
        end
        prev_at = k;
        acks++;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    vectors++;
    if (acks != 10) begin
      miscompares++;
      $display("FAIL back_to_back count: got %0d acks expected 10", acks);
    end
    m_scnt = 0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h800;
    step();
    vectors++;
    if (mem_ren !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid access: got ren=%b busy=%b expected 1,1", mem_ren, busy);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({mem_ren, mem_wen, busy, i_ack, d_ack} !== 5'd0 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid drop: got ren=%b wen=%b busy=%b acks=%b%b irdata=%h drdata=%h expected 0",
               mem_ren, mem_wen, busy, i_ack, d_ack, i_rdata, d_rdata);
    end
    d_req = 1'b0;
    step();
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++;
      if (i_ack || d_ack || busy) begin
        miscompares++;
        $display("FAIL reset_mid quiet: got acks=%b%b busy=%b expected 0", i_ack, d_ack, busy);
      end
    end
    do_txn(1'b0, 1'b0, 32'h900, 32'd0, 4'd0, "after_reset");
  endtask

  task automatic test_latency1();
    int busy_n, ack_at;
    l1_i_req = 1'b1; l1_i_addr = 32'hA00;
    busy_n = 0; ack_at = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      busy_n += int'(l1_busy);
      if (l1_d_ack) begin
        vectors++; miscompares++;
        $display("FAIL lat1 d_ack: got 1 expected 0");
      end
      if (l1_i_ack) begin
        ack_at = k;
        l1_i_req = 1'b0;
        vectors++;
        if (l1_i_rdata !== mem_model(32'hA00)) begin
          miscompares++;
          $display("FAIL lat1 rdata: got %h expected %h", l1_i_rdata, mem_model(32'hA00));
        end
      end
    end
    vectors++;
    if (ack_at != 2 || busy_n != 2) begin
      miscompares++;
      $display("FAIL lat1 timing: ack at %0d busy %0d cycles expected 2,2", ack_at, busy_n);
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_same_edge();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-side MMU refill path (read-only) and the data-side MMU refill/write-back path (read/write).
- Sits between the two MMU instances and the memory model.
- Serialises requests with a fixed-latency access sequencer and returns a one-cycle ack plus registered read data to the winning side.
- Data side has priority, with a starvation guard for the instruction side.

Parameters:
LATENCY, 2, memory access cycles per transaction (strobes held this long); legal range 1..15
MAX_D_BURST, 4, consecutive D grants allowed while I is waiting before I is forced through; legal range 1..15

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high
i_req  input  1  I-side request, held high until i_ack
i_addr  input  32  I-side word address
i_ack  output  1  one-cycle completion pulse to I-side
i_rdata  output  32  I-side read data, registered
d_req  input  1  D-side request, held high until d_ack
d_wen  input  1  D-side write (1) / read (0)
d_addr  input  32  D-side address
d_wdata  input  32  D-side write data
d_bsel  input  4  D-side byte-select vector
d_ack  output  1  one-cycle completion pulse to D-side
d_rdata  output  32  D-side read data, registered
mem_addr  output  32  memory address
mem_wdata  output  32  memory write data
mem_ren  output  1  memory read strobe
mem_wen  output  1  memory write strobe
mem_bsel  output  4  memory byte selector
mem_rdata  input  32  memory read data
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; latched request registers 0; starvation counter 0; last_grant = I.
- FSM states:
  - IDLE: at a clock edge with i_req or d_req high, arbitrate, then:
    - latch addr, wdata, bsel and wen of the winner; for I: bsel = 4'b1111, wen = 0.
    - record the winner in the grant register.
    - load cnt = LATENCY-1 and go to ACCESS.
    - With no request: stay in IDLE.
  - ACCESS:
    - mem_addr, mem_wdata and mem_bsel are driven from the latched registers.
    - mem_ren = !wen and mem_wen = wen, both held for exactly LATENCY cycles.
    - cnt decrements each edge. At the edge where cnt==0: on a read, capture mem_rdata into the winner's rdata register; go to RESP.
  - RESP: the winner's ack is high for this one cycle; strobes are low; go to IDLE on the next edge.
- Latency: a request sampled at edge E0 produces an ack high between edges E0+LATENCY and E0+LATENCY+1. Back-to-back transactions start no sooner than the IDLE edge after RESP (throughput one transaction per LATENCY+2 cycles).
- Requester rule: req stays high until ack is seen and drops at the edge ending RESP. A req still high in IDLE is treated as a new request.
- Arbitration (default):
  - d_req wins over i_req when both are high at the same edge.
  - The starvation counter increments on each D grant made while i_req is high.
  - When the counter equals MAX_D_BURST and i_req is high, I wins.
  - The counter clears on any I grant, or in IDLE when i_req is low.
- Data hold:
  - i_rdata and d_rdata hold their value until overwritten by a later read completing for that side.
  - D writes never change d_rdata.
  - The I side never writes.
- Inputs changing mid-transaction are ignored, because the latched copies drive memory.
- Reset mid-transaction: return immediately to IDLE; strobes drop; no ack is issued; the in-flight access is discarded; rdata registers clear to 0.
- d_bsel = 0 on a write is passed through unchanged: the strobe is still asserted and memory writes no bytes.

Optional Feature:
- Macro: MEMARB_ROUND_ROBIN_EN.
- Defined:
  - Arbitration is round-robin. When both requests are high, the side not recorded in last_grant wins; last_grant updates on every grant.
  - A single requester always wins.
  - MAX_D_BURST and the starvation counter are not built.
- Undefined: fixed D-priority with the starvation guard as described in Behaviour.

Test Plan:
- LATENCY=2, i_req with i_addr=0x100 sampled at edge 0, mem_rdata=0xDEADBEEF -> mem_ren high for exactly cycles 0-1, mem_bsel=4'hF, i_ack high for one cycle after edge 2, i_rdata=0xDEADBEEF; d_ack stays 0.
- d_req write with d_addr=0x200, d_wdata=0x12345678, d_bsel=4'b0011 -> mem_wen high for 2 cycles, mem_ren 0, d_ack pulse after edge 2, d_rdata unchanged.
- i_req and d_req both high at the same edge (default build) -> D is served first; I is served in the next transaction starting 4 edges after the first grant.
- i_req and d_req held high continuously, MAX_D_BURST=4 -> grant order D,D,D,D,I,D,D,D,D,I; with MEMARB_ROUND_ROBIN_EN the order is D,I,D,I (I first if last_grant=D).
- reset asserted one cycle into ACCESS -> strobes, busy and all acks drop immediately; no ack follows; i_rdata and d_rdata read 0; a new request after reset completes normally.
- LATENCY=1 with a single read -> ack one cycle after acceptance; busy high for exactly 2 cycles.
